// File: rtl/bcd2bin_arbiter.sv
// Round-robin arbiter sharing one bcd2bin converter core between N_REQ requesters.
// Validates the winner's BCD operand, launches the core, guards against stale/hung done, returns result with ack.
module bcd2bin_arbiter #(
  parameter int N_REQ       = 2,
  parameter int BCD_W       = 20,
  parameter int BIN_W       = 16,
  parameter int TIMEOUT_CYC = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*BCD_W-1:0] bcd_in,
  output logic [N_REQ-1:0]       ack,
  output logic [BIN_W-1:0]       bin_out,
  output logic                   err,
  output logic                   busy,
  output logic                   conv_init,
  output logic [BCD_W-1:0]       conv_A,
  input  logic [BIN_W-1:0]       conv_result,
  input  logic                   conv_done,
  output logic [1:0]             state_dbg
);

  // Handshake: a requester raises req (level) and holds it until its one-cycle ack;
  // req/bcd_in are only sampled in IDLE, so anything after the grant is ignored.
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   pick;
  logic            any_req;
  logic [BCD_W-1:0] sel_bcd;
  logic            bcd_ok;
  logic [CW-1:0]   wait_cnt;
  logic            done_ok;
  logic            timeout;

  // Round-robin search starting one past the previous winner.
  always_comb begin
    int idx;
    pick = last_grant;
    any_req = 1'b0;
    idx = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (!any_req && req[GW'(idx)]) begin
        pick = GW'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign sel_bcd = bcd_in[pick*BCD_W +: BCD_W];

  always_comb begin
    bcd_ok = 1'b1;
    for (int d = 0; d < BCD_W / 4; d++) begin
      if (sel_bcd[d*4 +: 4] > 4'd9) bcd_ok = 1'b0;
    end
  end

  // First WAIT cycle (wait_cnt==0) ignores done left over from a previous conversion.
  assign done_ok = (state == S_WAIT) && (wait_cnt != '0) && conv_done;
  assign timeout = (state == S_WAIT) && !done_ok && (wait_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    conv_init = 1'b0;
    busy      = (state != S_IDLE);
    state_dbg = state;
    ack       = '0;
    case (state)
      S_IDLE: begin
        if (any_req) state_nxt = bcd_ok ? S_LAUNCH : S_RESP;
      end
      S_LAUNCH: begin
        conv_init = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (done_ok || timeout) state_nxt = S_RESP;
      end
      S_RESP: begin
        for (int i = 0; i < N_REQ; i++) ack[i] = (last_grant == GW'(i));
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GW'(N_REQ - 1);
      conv_A     <= '0;
      wait_cnt   <= '0;
      bin_out    <= '0;
      err        <= 1'b0;
    end else begin
      if (state == S_IDLE && any_req) begin
        last_grant <= pick;
        conv_A     <= sel_bcd;
        if (!bcd_ok) begin
          bin_out <= '0;
          err     <= 1'b1;
        end
      end
      if (state == S_LAUNCH) wait_cnt <= '0;
      if (state == S_WAIT)   wait_cnt <= wait_cnt + CW'(1);
      if (done_ok) begin
        bin_out <= conv_result;
        err     <= 1'b0;
      end
      if (timeout) begin
        bin_out <= '0;
        err     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd2bin_arbiter.sv
// Directed bench for bcd2bin_arbiter with a behavioural bcd2bin core model.
// Covers reset, single conversion, round-robin, invalid BCD, timeout, stale done and mid-run reset.
module tb_bcd2bin_arbiter;
  localparam int N_REQ       = 2;
  localparam int BCD_W       = 20;
  localparam int BIN_W       = 16;
  localparam int TIMEOUT_CYC = 128;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*BCD_W-1:0] bcd_in;
  logic [N_REQ-1:0]       ack;
  logic [BIN_W-1:0]       bin_out;
  logic                   err;
  logic                   busy;
  logic                   conv_init;
  logic [BCD_W-1:0]       conv_A;
  logic [BIN_W-1:0]       conv_result;
  logic                   conv_done;
  logic [1:0]             state_dbg;

  int checks = 0;
  int failures = 0;
  int onehot_bad = 0;

  // core model controls
  int core_lat;
  bit core_hang;
  bit stale_mode;
  int core_cnt;
  bit core_run;

  logic [BIN_W-1:0] exp_q[$];
  logic [N_REQ-1:0] exp_ack_q[$];

  bcd2bin_arbiter #(
    .N_REQ(N_REQ), .BCD_W(BCD_W), .BIN_W(BIN_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .bcd_in(bcd_in), .ack(ack),
    .bin_out(bin_out), .err(err), .busy(busy), .conv_init(conv_init),
    .conv_A(conv_A), .conv_result(conv_result), .conv_done(conv_done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [BIN_W-1:0] bcd_to_bin(input logic [BCD_W-1:0] b);
    int v;
    v = 0;
    for (int d = BCD_W/4 - 1; d >= 0; d--) v = v * 10 + int'(b[d*4 +: 4]);
    return v[BIN_W-1:0];
  endfunction

  // Core model: done is a level cleared by init; stale_mode raises a bogus done right after init.
  always @(posedge clk) begin
    if (rst) begin
      conv_done   <= 1'b0;
      conv_result <= '0;
      core_cnt    <= 0;
      core_run    <= 1'b0;
    end else if (conv_init) begin
      conv_done   <= stale_mode;
      conv_result <= 16'hBEEF;
      core_cnt    <= core_lat;
      core_run    <= !core_hang;
    end else if (core_run) begin
      if (core_cnt == 0) begin
        conv_done   <= 1'b1;
        conv_result <= bcd_to_bin(conv_A);
        core_run    <= 1'b0;
      end else begin
        core_cnt  <= core_cnt - 1;
        conv_done <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if ($countones(ack) > 1) onehot_bad <= onehot_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input int limit, output logic [N_REQ-1:0] a, output int cyc);
    a = '0;
    cyc = 0;
    while (cyc < limit && a == '0) begin
      @(negedge clk);
      cyc++;
      a = ack;
    end
  endtask

  initial begin
    logic [N_REQ-1:0] a;
    int cyc;
    logic [BIN_W-1:0] eb;
    logic [N_REQ-1:0] ea;

    rst = 1'b1; req = '0; bcd_in = '0;
    core_lat = 3; core_hang = 1'b0; stale_mode = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_ack", ack, 0);
    check("rst_bin", bin_out, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_init", conv_init, 0);
    check("rst_convA", conv_A, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    @(negedge clk);

    // single conversion on requester 0
    bcd_in[19:0] = 20'h12345;
    req = 2'b01;
    @(negedge clk);
    check("t1_init", conv_init, 1);
    check("t1_convA", conv_A, 20'h12345);
    @(negedge clk);
    check("t1_init_pulse", conv_init, 0);
    check("t1_busy", busy, 1);
    wait_ack(50, a, cyc);
    check("t1_ack", a, 2'b01);
    check("t1_bin", bin_out, 16'h3039);
    check("t1_err", err, 0);
    check("t1_lat", cyc, core_lat + 2);
    req = '0;
    @(negedge clk);
    check("t1_idle_busy", busy, 0);
    check("t1_ack_once", ack, 0);
    check("t1_bin_hold", bin_out, 16'h3039);

    // both requesters held from reset: strict alternation starting with req0
    rst = 1'b1;
    req = 2'b11;
    bcd_in = {20'h65535, 20'h00099};
    core_lat = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_ack_q.push_back(2'b01); exp_q.push_back(16'h0063);
      exp_ack_q.push_back(2'b10); exp_q.push_back(16'hFFFF);
    end
    for (int i = 0; i < 4; i++) begin
      wait_ack(50, a, cyc);
      ea = exp_ack_q.pop_front();
      eb = exp_q.pop_front();
      check("t2_ack", a, ea);
      check("t2_bin", bin_out, eb);
      if (i == 3) req = '0;
    end
    @(negedge clk);

    // invalid BCD digit on requester 1: no core launch
    bcd_in[39:20] = 20'h0001A;
    req = 2'b10;
    wait_ack(10, a, cyc);
    check("t3_ack", a, 2'b10);
    check("t3_err", err, 1);
    check("t3_bin", bin_out, 0);
    check("t3_lat", cyc, 1);
    check("t3_no_init", conv_init, 0);
    req = '0;
    repeat (2) @(negedge clk);

    // hung core: timeout after TIMEOUT_CYC wait cycles
    core_hang = 1'b1;
    bcd_in[19:0] = 20'h00001;
    req = 2'b01;
    @(negedge clk);
    check("t4_init", conv_init, 1);
    wait_ack(TIMEOUT_CYC + 20, a, cyc);
    check("t4_ack", a, 2'b01);
    check("t4_err", err, 1);
    check("t4_bin", bin_out, 0);
    check("t4_lat", cyc, TIMEOUT_CYC + 1);
    req = '0;
    @(negedge clk);
    check("t4_busy_fall", busy, 0);
    core_hang = 1'b0;

    // stale done right after init, real done 20 cycles later
    stale_mode = 1'b1;
    core_lat = 20;
    bcd_in[39:20] = 20'h00777;
    req = 2'b10;
    @(negedge clk);
    check("t5_init", conv_init, 1);
    wait_ack(60, a, cyc);
    check("t5_ack", a, 2'b10);
    check("t5_bin", bin_out, 16'h0309);
    check("t5_err_clr", err, 0);
    check("t5_lat", cyc, core_lat + 3);
    req = '0;
    stale_mode = 1'b0;
    @(negedge clk);

    // reset during WAIT, then a fresh conversion for the still-pending req0
    core_lat = 10;
    bcd_in[19:0] = 20'h00042;
    req = 2'b01;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("t6_in_wait", state_dbg, 2);
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_init", conv_init, 0);
    check("t6_ack", ack, 0);
    check("t6_state", state_dbg, 0);
    check("t6_bin_rst", bin_out, 0);
    rst = 1'b0;
    wait_ack(60, a, cyc);
    check("t6_ack_fresh", a, 2'b01);
    check("t6_bin", bin_out, 16'h002A);
    check("t6_err", err, 0);
    check("t6_lat", cyc, core_lat + 4);
    req = '0;
    repeat (2) @(negedge clk);

    check("ack_onehot", onehot_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
